// File: rtl/debounce_pulse_pkg.sv
// Shared types and default constants for the debounce_pulse button front end.
package debounce_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_REPEAT_CYCLES = 1000;

endpackage

// File: rtl/debounce_pulse_sync_2ff.sv
// Two-flop synchronizer bringing the raw asynchronous button level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/debounce_pulse.sv
// Button debouncer: synchronizer + 4-state stability FSM, one-clock pulse per accepted press.
// Optional auto-repeat while held is enabled by defining DEBOUNCE_AUTOREPEAT_EN.
module debounce_pulse
    import debounce_pulse_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2 || longint'(STABLE_CYCLES) > (longint'(1) << CNT_W) ||
        REPEAT_CYCLES < 2 || longint'(REPEAT_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_param
        $error("debounce_pulse: STABLE_CYCLES/REPEAT_CYCLES out of range for CNT_W");
    end

    logic             btn_s;
    state_t           state_p0, state_nxt;
    logic [CNT_W-1:0] cnt_p0, cnt_nxt;
    logic             press_acc;
    logic             rpt_fire;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_s)
    );

    // Stage p0: stability FSM. cnt only counts up to CNT_LAST and is cleared on every exit.
    always_comb begin
        state_nxt = state_p0;
        cnt_nxt   = cnt_p0;
        press_acc = 1'b0;
        case (state_p0)
            IDLE: begin
                if (btn_s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt_p0 == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    press_acc = 1'b1;
                end else begin
                    cnt_nxt = cnt_p0 + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt_p0 == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_p0 + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rcnt_p0, rcnt_nxt;

    // Repeat timer runs only while PRESSED is held; any other cycle reloads it to zero.
    always_comb begin
        rcnt_nxt = '0;
        rpt_fire = 1'b0;
        if (state_p0 == PRESSED && state_nxt == PRESSED) begin
            if (rcnt_p0 == RPT_LAST) begin
                rpt_fire = 1'b1;
            end else begin
                rcnt_nxt = rcnt_p0 + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt_p0 <= '0;
        end else begin
            rcnt_p0 <= rcnt_nxt;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_p0 <= IDLE;
            cnt_p0   <= '0;
            pulse    <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            cnt_p0   <= cnt_nxt;
            pulse    <= press_acc | rpt_fire;
        end
    end

    assign level = (state_p0 == PRESSED) || (state_p0 == RELEASE_WAIT);

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed self-checking bench for debounce_pulse (STABLE_CYCLES=4, REPEAT_CYCLES=8).
module tb_debounce_pulse;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic pulse;
    logic level;
    int   checks = 0;
    int   errors = 0;

    debounce_pulse #(
        .STABLE_CYCLES (4),
        .CNT_W         (16),
        .REPEAT_CYCLES (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_in),
        .pulse  (pulse),
        .level  (level)
    );

    always #5 clk = ~clk;

    // One rising edge, then sample/drive 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_idle();
        btn_in = 1'b0;
        for (int i = 0; i < 12; i++) step();
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        btn_in = 1'b1;
        step();
        step();
        checks++;
        if (pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", pulse); end
        checks++;
        if (level !== 1'b0) begin errors++; $display("FAIL reset_level: got %b want 0", level); end
        btn_in = 1'b0;
        rst    = 1'b1;
        for (int e = 0; e < 6; e++) begin
            step();
            checks++;
            if (pulse !== 1'b0 || level !== 1'b0) begin
                errors++;
                $display("FAIL reset_release e%0d: got pulse=%b level=%b want 0/0", e, pulse, level);
            end
        end
    endtask

    task automatic test_clean_press();
        settle_idle();
        btn_in = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            checks++;
            if (pulse !== (e == 6) || level !== (e >= 6)) begin
                errors++;
                $display("FAIL clean_press e%0d: got pulse=%b level=%b want %b/%b",
                         e, pulse, level, (e == 6), (e >= 6));
            end
        end
        btn_in = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            checks++;
            if (pulse !== 1'b0 || level !== (e < 6)) begin
                errors++;
                $display("FAIL clean_release e%0d: got pulse=%b level=%b want 0/%b",
                         e, pulse, level, (e < 6));
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] pat;
        int         npulse;
        pat    = 4'b0101;
        npulse = 0;
        settle_idle();
        for (int e = 0; e < 15; e++) begin
            btn_in = (e < 4) ? pat[e] : 1'b1;
            step();
            if (pulse === 1'b1) npulse++;
            checks++;
            if (pulse !== (e == 10) || level !== (e >= 10)) begin
                errors++;
                $display("FAIL bounce e%0d: got pulse=%b level=%b want %b/%b",
                         e, pulse, level, (e == 10), (e >= 10));
            end
        end
        checks++;
        if (npulse != 1) begin errors++; $display("FAIL bounce_count: got %0d pulses want 1", npulse); end
        settle_idle();
    endtask

    task automatic test_glitch();
        settle_idle();
        for (int e = 0; e < 12; e++) begin
            btn_in = (e < 3);
            step();
            checks++;
            if (pulse !== 1'b0 || level !== 1'b0) begin
                errors++;
                $display("FAIL glitch e%0d: got pulse=%b level=%b want 0/0", e, pulse, level);
            end
        end
    endtask

    task automatic test_release_bounce();
        settle_idle();
        btn_in = 1'b1;
        for (int e = 0; e < 10; e++) step();
        checks++;
        if (level !== 1'b1) begin errors++; $display("FAIL rb_pressed: got level=%b want 1", level); end
        for (int e = 0; e < 12; e++) begin
            btn_in = (e >= 2);
            step();
            checks++;
            if (pulse !== 1'b0 || level !== 1'b1) begin
                errors++;
                $display("FAIL release_bounce e%0d: got pulse=%b level=%b want 0/1", e, pulse, level);
            end
        end
        btn_in = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            checks++;
            if (level !== (e < 6)) begin
                errors++;
                $display("FAIL rb_clean_release e%0d: got level=%b want %b", e, level, (e < 6));
            end
        end
    endtask

    task automatic test_reset_mid_press();
        // Reset during PRESS_WAIT, then release and re-press.
        settle_idle();
        btn_in = 1'b1;
        for (int e = 0; e < 4; e++) step();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (pulse !== 1'b0 || level !== 1'b0) begin
            errors++;
            $display("FAIL rst_press_wait: got pulse=%b level=%b want 0/0", pulse, level);
        end
        step();
        btn_in = 1'b0;
        rst    = 1'b1;
        for (int e = 0; e < 6; e++) step();
        btn_in = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            checks++;
            if (pulse !== (e == 6) || level !== (e >= 6)) begin
                errors++;
                $display("FAIL rst_repress e%0d: got pulse=%b level=%b want %b/%b",
                         e, pulse, level, (e == 6), (e >= 6));
            end
        end
        // Reset while PRESSED with the button still held: progress must be discarded.
        #2 rst = 1'b0;
        #1;
        checks++;
        if (pulse !== 1'b0 || level !== 1'b0) begin
            errors++;
            $display("FAIL rst_pressed: got pulse=%b level=%b want 0/0", pulse, level);
        end
        step();
        rst = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            checks++;
            if (pulse !== (e == 6) || level !== (e >= 6)) begin
                errors++;
                $display("FAIL rst_held e%0d: got pulse=%b level=%b want %b/%b",
                         e, pulse, level, (e == 6), (e >= 6));
            end
        end
        settle_idle();
    endtask

    task automatic test_autorepeat();
        int  npulse;
        logic prev;
        logic exp_p;
        npulse = 0;
        prev   = 1'b0;
        settle_idle();
        btn_in = 1'b1;
        for (int e = 0; e < 37; e++) begin
            step();
`ifdef DEBOUNCE_AUTOREPEAT_EN
            exp_p = (e == 6) || (e == 14) || (e == 22) || (e == 30);
`else
            exp_p = (e == 6);
`endif
            if (pulse === 1'b1) npulse++;
            checks++;
            if (pulse !== exp_p) begin
                errors++;
                $display("FAIL autorepeat e%0d: got pulse=%b want %b", e, pulse, exp_p);
            end
            checks++;
            if (prev === 1'b1 && pulse === 1'b1) begin
                errors++;
                $display("FAIL pulse_back_to_back e%0d: got two high cycles want one", e);
            end
            prev = pulse;
        end
        checks++;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        if (npulse != 4) begin errors++; $display("FAIL autorepeat_count: got %0d want 4", npulse); end
`else
        if (npulse != 1) begin errors++; $display("FAIL autorepeat_count: got %0d want 1", npulse); end
`endif
        settle_idle();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_release_bounce();
        test_reset_mid_press();
        test_autorepeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
